// File: rtl/axil2emif.sv
// AXI-Lite slave to asynchronous EMIF bridge: one outstanding access, programmable setup/strobe timing.
// Define AXIL2EMIF_ARDY_EN to stretch the strobe while emif_ardy is low.
module axil2emif #(
  parameter logic [31:0] AXIL_ADDR_BASE  = 32'h0000_0000,
  parameter int unsigned AXIL_ADDR_WIDTH = 16,
  parameter logic [23:0] EMIF_ADDR_BASE  = 24'h00_0000,
  parameter int unsigned SETUP_CYC       = 2,
  parameter int unsigned STROBE_CYC      = 3
) (
  input  logic        eclk,
  input  logic        rst,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_awaddr,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  input  logic [31:0] s_axil_wdata,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  output logic [1:0]  s_axil_bresp,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  input  logic [31:0] s_axil_araddr,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        nce,
  output logic        noe,
  output logic        nwe,
  output logic [23:0] emif_addr,
  output logic [31:0] emif_data_o,
  input  logic [31:0] emif_data_i,
  output logic        emif_data_oe,
  input  logic        emif_ardy
);

  localparam int unsigned CNT_W       = 4;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  if (AXIL_ADDR_WIDTH < 3 || AXIL_ADDR_WIDTH > 25) begin : g_bad_aw
    $error("axil2emif: AXIL_ADDR_WIDTH must be in 3..25");
  end
  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("axil2emif: SETUP_CYC must be in 1..15");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
    $error("axil2emif: STROBE_CYC must be in 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_q;
  logic               prefer_wr_q;
  logic               awready_q;
  logic               wready_q;
  logic               arready_q;
  logic               bvalid_q;
  logic               rvalid_q;
  logic [1:0]         bresp_q;
  logic [1:0]         rresp_q;
  logic [31:0]        rdata_q;
  logic               nce_q;
  logic               noe_q;
  logic               nwe_q;
  logic [23:0]        emif_addr_q;
  logic [31:0]        emif_data_q;
  logic               emif_oe_q;

  logic        wr_elig_c;
  logic        rd_elig_c;
  logic        pick_wr_c;
  logic        accept_c;
  logic [31:0] acc_addr_c;
  logic [31:0] off_c;
  logic        in_win_c;
  logic [23:0] word_c;
  logic        strobe_done_c;

  // Arbitration: the round-robin flag breaks ties only when both types are eligible.
  assign wr_elig_c = s_axil_awvalid & s_axil_wvalid;
  assign rd_elig_c = s_axil_arvalid;
  assign pick_wr_c = wr_elig_c & (~rd_elig_c | prefer_wr_q);

  // A ready registered high in IDLE marks the handshake cycle.
  assign accept_c   = awready_q | arready_q;
  assign acc_addr_c = wr_q ? s_axil_awaddr : s_axil_araddr;
  assign off_c      = acc_addr_c - AXIL_ADDR_BASE;
  assign in_win_c   = {1'b0, off_c} < (33'd1 << AXIL_ADDR_WIDTH);
  assign word_c     = EMIF_ADDR_BASE + 24'(off_c >> 2);

`ifdef AXIL2EMIF_ARDY_EN
  assign strobe_done_c = (cnt_q == '0) & emif_ardy;
`else
  logic unused_ardy;
  assign unused_ardy   = emif_ardy;
  assign strobe_done_c = (cnt_q == '0);
`endif

  always_ff @(posedge eclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      prefer_wr_q <= 1'b1;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      nce_q       <= 1'b1;
      noe_q       <= 1'b1;
      nwe_q       <= 1'b1;
      emif_addr_q <= '0;
      emif_data_q <= '0;
      emif_oe_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            if (in_win_c) begin
              state_q     <= S_SETUP;
              cnt_q       <= CNT_W'(SETUP_CYC - 1);
              nce_q       <= 1'b0;
              emif_addr_q <= word_c;
              emif_oe_q   <= wr_q;
              if (wr_q) begin
                emif_data_q <= s_axil_wdata;
              end
            end else begin
              // Out-of-window: answer immediately, no bus cycle.
              state_q  <= S_RESP;
              bvalid_q <= wr_q;
              rvalid_q <= ~wr_q;
              if (wr_q) begin
                bresp_q <= RESP_DECERR;
              end else begin
                rresp_q <= RESP_DECERR;
                rdata_q <= '0;
              end
            end
          end else if (wr_elig_c | rd_elig_c) begin
            wr_q        <= pick_wr_c;
            prefer_wr_q <= ~pick_wr_c;
            awready_q   <= pick_wr_c;
            wready_q    <= pick_wr_c;
            arready_q   <= ~pick_wr_c;
          end
        end

        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= S_STROBE;
            cnt_q   <= CNT_W'(STROBE_CYC - 1);
            noe_q   <= wr_q;
            nwe_q   <= ~wr_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_STROBE: begin
          if (strobe_done_c) begin
            state_q <= S_HOLD;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
            if (!wr_q) begin
              rdata_q <= emif_data_i;
            end
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_HOLD: begin
          state_q   <= S_RESP;
          nce_q     <= 1'b1;
          emif_oe_q <= 1'b0;
          bvalid_q  <= wr_q;
          rvalid_q  <= ~wr_q;
          if (wr_q) begin
            bresp_q <= RESP_OKAY;
          end else begin
            rresp_q <= RESP_OKAY;
          end
        end

        S_RESP: begin
          if ((bvalid_q & s_axil_bready) | (rvalid_q & s_axil_rready)) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_arready = arready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign nce            = nce_q;
  assign noe            = noe_q;
  assign nwe            = nwe_q;
  assign emif_addr      = emif_addr_q;
  assign emif_data_o    = emif_data_q;
  assign emif_data_oe   = emif_oe_q;

endmodule

// File: tb/tb_axil2emif.sv
// Bench for axil2emif: directed vector table, arbitration/reset/ready sequences and a randomized
// run checked against an address-window and memory reference model.
module tb_axil2emif;

  localparam logic [31:0] ABASE  = 32'h4000_0000;
  localparam int unsigned AW     = 16;
  localparam logic [23:0] EBASE  = 24'h10_0000;
  localparam int          SETUP  = 2;
  localparam int          STROBE = 3;
`ifdef AXIL2EMIF_ARDY_EN
  localparam bit ARDY = 1'b1;
`else
  localparam bit ARDY = 1'b0;
`endif

  logic        eclk, rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, rdata;
  logic        nce, noe, nwe, emif_data_oe, emif_ardy;
  logic [23:0] emif_addr;
  logic [31:0] emif_data_o, emif_data_i;

  axil2emif #(
    .AXIL_ADDR_BASE (ABASE),
    .AXIL_ADDR_WIDTH(AW),
    .EMIF_ADDR_BASE (EBASE),
    .SETUP_CYC      (SETUP),
    .STROBE_CYC     (STROBE)
  ) dut (
    .eclk(eclk), .rst(rst),
    .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
    .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .nce(nce), .noe(noe), .nwe(nwe), .emif_addr(emif_addr),
    .emif_data_o(emif_data_o), .emif_data_i(emif_data_i), .emif_data_oe(emif_data_oe),
    .emif_ardy(emif_ardy)
  );

  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          nce_lo, noe_lo, nwe_lo, oe_hi;
    int          addr_err, data_err, arb_err, stall_err;
    logic [23:0] eaddr;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          tmo, got_b;
  } obs_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr, wd;
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [23:0] ea;
    int          nce;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] emem [logic [23:0]];       // EMIF device contents, by EMIF word address
  logic [31:0] rmem [int unsigned];       // reference contents, by window word offset

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] unwritten(input logic [23:0] a);
    return 32'hA5A5_0000 ^ {8'h00, a};
  endfunction

  function automatic logic [31:0] emif_rd(input logic [23:0] a);
    return emem.exists(a) ? emem[a] : unwritten(a);
  endfunction

  // Reference: window decode, expected bus cycle lengths and memory contents.
  function automatic void model(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                input int stall, output logic [1:0] resp, output logic [31:0] rd,
                                output logic [23:0] ea, output int nce_n, output int str_n);
    logic [31:0] off;
    int unsigned key;
    bit in_win;
    off    = addr - ABASE;
    in_win = off < (32'd1 << AW);
    key    = off / 4;
    ea     = 24'((32'(EBASE) + key) % (1 << 24));
    str_n  = in_win ? STROBE + (ARDY ? stall : 0) : 0;
    nce_n  = in_win ? SETUP + str_n + 1 : 0;
    resp   = in_win ? 2'b00 : 2'b11;
    rd     = '0;
    if (in_win && wr) rmem[key] = wd;
    else if (in_win) rd = rmem.exists(key) ? rmem[key] : unwritten(ea);
  endfunction

  task automatic drive_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    if (wr) begin
      awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = wd;
    end else begin
      arvalid = 1'b1; araddr = addr;
    end
  endtask

  // Returns at the negedge just after the handshake edge.
  task automatic wait_accept(output bit got_wr, output int rdy_w, output bit tmo, output bit gap);
    got_wr = 1'b0; rdy_w = 0; tmo = 1'b1; gap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge eclk);
      if (awready || arready) begin
        got_wr = awready;
        tmo    = 1'b0;
        rdy_w  = (awready == wready) ? 1 : 10;
        gap    = !nce;
        break;
      end
    end
    if (!tmo) begin
      @(negedge eclk);
      if (awready || wready || arready) rdy_w++;
      if (got_wr) begin awvalid = 1'b0; wvalid = 1'b0; end
      else arvalid = 1'b0;
    end
  endtask

  task automatic finish_txn(input bit wr, input logic [31:0] wd, input int stall,
                            input int bdelay, output obs_t o);
    int k;
    bit seen;
    o = '{default: 0};
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bvalid || rvalid) begin seen = 1'b1; break; end
      if (!nce) begin
        if (o.nce_lo == 0) o.eaddr = emif_addr;
        else if (emif_addr !== o.eaddr) o.addr_err++;
        o.nce_lo++;
      end else if (!noe || !nwe || emif_data_oe) o.addr_err++;
      if (!noe) o.noe_lo++;
      if (!nwe) begin o.nwe_lo++; emem[emif_addr] = emif_data_o; end
      if (emif_data_oe) begin o.oe_hi++; if (emif_data_o !== wd) o.data_err++; end
      if (awready || arready) o.arb_err++;
      if (!noe || !nwe) k++;
      emif_ardy   = (!noe || !nwe) && (k >= STROBE + stall);
      emif_data_i = !noe ? emif_rd(emif_addr) : $urandom;
      @(negedge eclk);
    end
    emif_ardy = 1'b0;
    o.tmo = !seen;
    if (seen) begin
      o.got_b = bvalid;
      o.resp  = bvalid ? bresp : rresp;
      o.rdata = rdata;
      for (int i = 0; i < bdelay; i++) begin
        @(negedge eclk);
        if (!(wr ? bvalid : rvalid) || (wr ? bresp : rresp) !== o.resp || rdata !== o.rdata ||
            awready || arready) o.stall_err++;
      end
      if (wr) bready = 1'b1; else rready = 1'b1;
      @(negedge eclk);
      bready = 1'b0; rready = 1'b0;
      if (bvalid || rvalid) o.stall_err++;
    end
  endtask

  task automatic check_txn(input string tag, input bit wr, input bit got_wr, input int rdy_w,
                           input bit atmo, input bit gap, input obs_t o, input logic [1:0] eresp,
                           input logic [31:0] erd, input logic [23:0] eea, input int enc,
                           input int estr);
    chk($sformatf("%s.accept_type", tag), 32'({atmo, got_wr}), 32'({1'b0, wr}));
    chk($sformatf("%s.ready_width", tag), 32'(rdy_w), 32'd1);
    chk($sformatf("%s.idle_gap", tag), 32'(gap), 32'd0);
    chk($sformatf("%s.resp_chan", tag), 32'(o.got_b), 32'(wr));
    chk($sformatf("%s.resp", tag), 32'(o.resp), 32'(eresp));
    if (!wr) chk($sformatf("%s.rdata", tag), o.rdata, erd);
    chk($sformatf("%s.nce_low", tag), 32'(o.nce_lo), 32'(enc));
    chk($sformatf("%s.strobe_low", tag), 32'(wr ? o.nwe_lo : o.noe_lo), 32'(estr));
    chk($sformatf("%s.other_strobe", tag), 32'(wr ? o.noe_lo : o.nwe_lo), 32'd0);
    chk($sformatf("%s.oe_high", tag), 32'(o.oe_hi), 32'(wr ? enc : 0));
    if (enc > 0) chk($sformatf("%s.emif_addr", tag), 32'(o.eaddr), 32'(eea));
    chk($sformatf("%s.protocol_errs", tag),
        32'(o.addr_err + o.data_err + o.arb_err + o.stall_err + int'(o.tmo)), 32'd0);
  endtask

  task automatic do_txn(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int stall, input int bdelay,
                        input logic [1:0] eresp, input logic [31:0] erd, input logic [23:0] eea,
                        input int enc, input int estr);
    bit gw, tm, gp;
    int rw;
    obs_t o;
    drive_req(wr, addr, wd);
    wait_accept(gw, rw, tm, gp);
    finish_txn(wr, wd, stall, bdelay, o);
    check_txn(tag, wr, gw, rw, tm, gp, o, eresp, erd, eea, enc, estr);
  endtask

  // Serve one already-requested transaction and check it against the reference model.
  task automatic serve_model(input string tag, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int bdelay);
    bit gw, tm, gp;
    int rw, en, es;
    obs_t o;
    logic [1:0] er;
    logic [31:0] ed;
    logic [23:0] ea;
    wait_accept(gw, rw, tm, gp);
    finish_txn(gw, wd, 0, bdelay, o);
    model(wr, addr, wd, 0, er, ed, ea, en, es);
    check_txn(tag, wr, gw, rw, tm, gp, o, er, ed, ea, en, es);
  endtask

  initial begin : main
    vec_t tv [10];
    logic [1:0] er;
    logic [31:0] ed, a, d;
    logic [23:0] ea;
    int en, es, n, sel;
    bit w;

    tv[0] = '{1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 2'b00, 32'h0,         24'h10_0004, 6};
    tv[1] = '{1'b0, 32'h4000_0010, 32'h0,         2'b00, 32'hDEAD_BEEF, 24'h10_0004, 6};
    tv[2] = '{1'b0, 32'h4000_0020, 32'h0,         2'b00, 32'h1234_5678, 24'h10_0008, 6};
    tv[3] = '{1'b0, 32'h4001_0000, 32'h0,         2'b11, 32'h0,         24'h0,       0};
    tv[4] = '{1'b1, 32'h4000_FFFF, 32'h0BAD_F00D, 2'b00, 32'h0,         24'h10_3FFF, 6};
    tv[5] = '{1'b0, 32'h4000_FFFC, 32'h0,         2'b00, 32'h0BAD_F00D, 24'h10_3FFF, 6};
    tv[6] = '{1'b1, 32'h3FFF_FFFC, 32'hFFFF_FFFF, 2'b11, 32'h0,         24'h0,       0};
    tv[7] = '{1'b0, 32'h4000_0023, 32'h0,         2'b00, 32'h1234_5678, 24'h10_0008, 6};
    tv[8] = '{1'b1, 32'h4001_0000, 32'h0000_0001, 2'b11, 32'h0,         24'h0,       0};
    tv[9] = '{1'b0, 32'h0000_0000, 32'h0,         2'b11, 32'h0,         24'h0,       0};

    rst = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; wdata = '0; araddr = '0; emif_data_i = '0; emif_ardy = 1'b0;
    emem[24'h10_0008] = 32'h1234_5678;
    rmem[8]           = 32'h1234_5678;

    repeat (3) @(negedge eclk);
    chk("reset.strobes", 32'({nce, noe, nwe}), 32'h7);
    chk("reset.emif_addr", 32'(emif_addr), 32'h0);
    chk("reset.emif_data", emif_data_o, 32'h0);
    chk("reset.handshake", 32'({emif_data_oe, awready, wready, arready, bvalid, rvalid}), 32'h0);
    chk("reset.resp_data", 32'({bresp, rresp}) | rdata, 32'h0);
    rst = 1'b0;
    @(negedge eclk);

    // Both types eligible straight out of reset: write first, read next, write again.
    drive_req(1'b1, ABASE + 32'h100, 32'h1111_1111);
    drive_req(1'b0, ABASE + 32'h100, 32'h0);
    serve_model("arb1.w", 1'b1, ABASE + 32'h100, 32'h1111_1111, 10);
    serve_model("arb1.r", 1'b0, ABASE + 32'h100, 32'h0, 0);
    drive_req(1'b1, ABASE + 32'h104, 32'h2222_2222);
    drive_req(1'b0, ABASE + 32'h104, 32'h0);
    serve_model("arb2.w", 1'b1, ABASE + 32'h104, 32'h2222_2222, 0);
    serve_model("arb2.r", 1'b0, ABASE + 32'h104, 32'h0, 2);

    for (int i = 0; i < 10; i++) begin
      model(tv[i].wr, tv[i].addr, tv[i].wd, 0, er, ed, ea, en, es);
      do_txn($sformatf("vec%0d", i), tv[i].wr, tv[i].addr, tv[i].wd, 0, i % 3, tv[i].resp,
             tv[i].rd, tv[i].ea, tv[i].nce, (tv[i].nce != 0) ? STROBE : 0);
    end

    // Ready held low for 4 extra strobe cycles.
    do_txn("ardy_stall", 1'b0, 32'h4000_0010, 32'h0, 4, 0, 2'b00, 32'hDEAD_BEEF, 24'h10_0004,
           ARDY ? 10 : 6, ARDY ? 7 : 3);

    // Reset asserted during the second strobe cycle of a write.
    begin
      bit gw, tm, gp;
      int rw;
      drive_req(1'b1, ABASE + 32'h40, 32'h5555_AAAA);
      wait_accept(gw, rw, tm, gp);
      n = 0;
      for (int i = 0; i < 20; i++) begin
        if (!nwe) n++;
        if (n == 2) break;
        @(negedge eclk);
      end
      chk("midrst.reached_strobe2", 32'(n), 32'd2);
      rst = 1'b1;
      @(negedge eclk);
      chk("midrst.strobes", 32'({nce, noe, nwe}), 32'h7);
      chk("midrst.data_oe", 32'(emif_data_oe), 32'h0);
      chk("midrst.handshake", 32'({awready, wready, arready, bvalid, rvalid}), 32'h0);
      rst = 1'b0;
      @(negedge eclk);
    end

    for (int i = 0; i < 40; i++) begin
      w   = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 7) a = ABASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      else if (sel < 9) a = ABASE + 32'h0000_FFF0 + 32'($urandom_range(0, 15));
      else if (i % 3 == 0) a = ABASE + 32'h0001_0000 + 32'($urandom_range(0, 255));
      else if (i % 3 == 1) a = ABASE - 32'($urandom_range(1, 64));
      else a = $urandom;
      d  = $urandom;
      es = int'($urandom_range(0, 3));
      begin
        int stall;
        stall = es;
        model(w, a, d, stall, er, ed, ea, en, es);
        do_txn($sformatf("rnd%0d", i), w, a, d, stall, int'($urandom_range(0, 3)), er, ed, ea,
               en, es);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil2emif.md
AXIL2EMIF -- requirements
Module: axil2emif

Interface
REQ-001 AXIL_ADDR_BASE, 32'h00000000, AXI-Lite byte address of window start.
REQ-002 AXIL_ADDR_WIDTH, 16, window size 2^N bytes; legal range 3..25.
REQ-003 EMIF_ADDR_BASE, 24'h000000, EMIF word address of window start.
REQ-004 SETUP_CYC, 2, setup cycles before strobe; legal range 1..15.
REQ-005 STROBE_CYC, 3, cycles with noe/nwe low; legal range 1..15. Hold is fixed at 1 cycle.
REQ-006 eclk  in  1  single clock for AXI-Lite and EMIF sides.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 s_axil_awvalid  in  1  write address valid.
REQ-009 s_axil_awready  out  1  write address accept.
REQ-010 s_axil_awaddr  in  32  write byte address.
REQ-011 s_axil_wvalid  in  1  write data valid.
REQ-012 s_axil_wready  out  1  write data accept.
REQ-013 s_axil_wdata  in  32  write data; full-word writes only, no byte strobes.
REQ-014 s_axil_bvalid  out  1  write response valid.
REQ-015 s_axil_bready  in  1  write response accept.
REQ-016 s_axil_bresp  out  2  OKAY 2'b00 or DECERR 2'b11.
REQ-017 s_axil_arvalid  in  1  read address valid.
REQ-018 s_axil_arready  out  1  read address accept.
REQ-019 s_axil_araddr  in  32  read byte address.
REQ-020 s_axil_rvalid  out  1  read data valid.
REQ-021 s_axil_rready  in  1  read data accept.
REQ-022 s_axil_rdata  out  32  read data.
REQ-023 s_axil_rresp  out  2  OKAY or DECERR.
REQ-024 nce  out  1  EMIF chip enable, active low.
REQ-025 noe  out  1  EMIF output enable, active low.
REQ-026 nwe  out  1  EMIF write enable, active low.
REQ-027 emif_addr  out  24  EMIF word address.
REQ-028 emif_data_o  out  32  EMIF write data.
REQ-029 emif_data_i  in  32  EMIF read data.
REQ-030 emif_data_oe  out  1  high means the bridge drives the data bus; the top level instantiates the tristate buffer.
REQ-031 emif_ardy  in  1  EMIF ready, active high; used only under REQ-049.

Function
REQ-032 The bridge shall handle one outstanding transaction. The FSM states are IDLE, SETUP, STROBE, HOLD and RESP. All outputs shall be registered.
REQ-033 In IDLE, a write is eligible when awvalid and wvalid are both high. A read is eligible when arvalid is high.
REQ-034 If a write and a read are both eligible, the bridge shall serve the type not served last, tracked by a round-robin flag. After reset the flag shall favour write.
REQ-035 Accept: a write shall assert awready and wready together for exactly one cycle; a read shall assert arready for exactly one cycle. Address and data shall be latched on that cycle.
REQ-036 Window check: the address is in the window when (addr - AXIL_ADDR_BASE) < 2^AXIL_ADDR_WIDTH, evaluated on the 32-bit unsigned difference.
- In window: emif_addr = EMIF_ADDR_BASE + (addr - AXIL_ADDR_BASE)[AXIL_ADDR_WIDTH-1:2], truncated to 24 bits with wrap-around.
REQ-037 An out-of-window access shall go directly to RESP with DECERR; rdata shall be 0 and no EMIF cycle shall occur.
REQ-038 Bus cycle timing:
- SETUP: SETUP_CYC cycles, nce low, noe/nwe high, address stable.
- STROBE: STROBE_CYC cycles, noe low (read) or nwe low (write).
- HOLD: 1 cycle with nce low and strobes high.
- Then RESP, with nce high.
REQ-039 For writes, emif_data_oe and emif_data_o shall be valid from the first SETUP cycle through HOLD. emif_data_oe shall be 0 at all other times.
REQ-040 For reads, rdata shall be sampled from emif_data_i on the last STROBE cycle.
REQ-041 RESP shall hold bvalid or rvalid, with resp and rdata stable, until the matching ready is high. The FSM shall then return to IDLE.
- No new accept shall occur in RESP, even if valids are pending.
REQ-042 Minimum idle gap: nce shall be high for at least 1 cycle between two bus cycles.
REQ-043 Unaligned address bits [1:0] shall be ignored.

Reset
REQ-044 While rst is high at a clock edge, the bridge shall set:
- nce, noe, nwe = 1
- emif_addr = 0, emif_data_o = 0, emif_data_oe = 0
- all ready and valid outputs = 0
- bresp, rresp and rdata = 0
- FSM = IDLE, round-robin flag = write
REQ-045 Reset mid-operation shall abort the bus cycle; nce, noe and nwe shall be high on the cycle after reset is sampled.

Configuration
REQ-046 The macro AXIL2EMIF_ARDY_EN shall control ready extension of the strobe.
REQ-047 With AXIL2EMIF_ARDY_EN defined, the bridge shall hold STROBE after STROBE_CYC expires while emif_ardy is low.
- Read data shall be sampled on the cycle in which emif_ardy is high and the strobe count is done.
REQ-048 Without AXIL2EMIF_ARDY_EN, emif_ardy shall be ignored and the strobe shall be exactly STROBE_CYC cycles.
REQ-049 emif_ardy shall be used only when AXIL2EMIF_ARDY_EN is defined.

Verification (AXIL_ADDR_BASE=0x40000000, EMIF_ADDR_BASE=0x100000, SETUP_CYC=2, STROBE_CYC=3)
REQ-050 Write 0xDEADBEEF to 0x40000010 -> emif_addr=0x100004, nwe low exactly 3 cycles, emif_data_o=0xDEADBEEF with oe high 6 cycles, bresp=OKAY.
REQ-051 Read 0x40000020 with emif_data_i=0x12345678 -> emif_addr=0x100008, noe low 3 cycles, rdata=0x12345678, rresp=OKAY.
REQ-052 AW, W and AR all valid from reset -> write served first, then read. Repeat with both eligible -> write served again (alternation).
REQ-053 Read 0x40010000 -> DECERR, rdata=0, nce never low. Hold bready low for 10 cycles on a write -> bvalid held and arready stays 0.
REQ-054 rst pulsed during the 2nd STROBE cycle -> next cycle nce=noe=nwe=1 and oe=0. With AXIL2EMIF_ARDY_EN and emif_ardy low 4 extra cycles -> noe low 7 cycles.
